// File: rtl/key_debounce_4_pkg.sv
// Shared constants for the four-channel key debouncer: FSM encoding and
// the default filter length for a 50 MHz clock.
package key_debounce_4_pkg;

   localparam logic [1:0] ST_UP      = 2'd0;
   localparam logic [1:0] ST_FILT_DN = 2'd1;
   localparam logic [1:0] ST_DOWN    = 2'd2;
   localparam logic [1:0] ST_FILT_UP = 2'd3;

   // 20 ms of stable level at 50 MHz
   localparam int DEB_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/key_debounce_4_filter_ch.sv
// Single-key conditioner: synchroniser, stability counter and up/down FSM
// producing a debounced level plus a one-cycle change strobe.
module key_filter_ch
   import key_debounce_4_pkg::*;
#(
   parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key,
   output logic o_value,
   output logic o_flag
);

   localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [1:0]             r_state;
   logic [CW-1:0]          r_cnt;
   logic                   r_value;
   logic                   r_flag;
   logic                   w_s;

   assign w_s     = r_sync[SYNC_STAGES-1];
   assign o_value = r_value;
   assign o_flag  = r_flag;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync  <= '1;
         r_state <= ST_UP;
         r_cnt   <= '0;
         r_value <= 1'b1;
         r_flag  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_key};
         r_flag <= 1'b0;
         case (r_state)
            ST_UP: begin
               if (!w_s) begin
                  r_state <= ST_FILT_DN;
                  r_cnt   <= '0;
               end
            end
            ST_FILT_DN: begin
               // any high sample is a bounce: drop back and requalify later
               if (w_s) begin
                  r_state <= ST_UP;
               end else if (r_cnt == CNT_MAX) begin
                  r_state <= ST_DOWN;
                  r_value <= 1'b0;
                  r_flag  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DOWN: begin
               if (w_s) begin
                  r_state <= ST_FILT_UP;
                  r_cnt   <= '0;
               end
            end
            default: begin
               if (!w_s) begin
                  r_state <= ST_DOWN;
               end else if (r_cnt == CNT_MAX) begin
                  r_state <= ST_UP;
                  r_value <= 1'b1;
                  r_flag  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/key_debounce_4.sv
// Four independent key conditioners; this level only fans the pins out
// to the per-channel filters and flattens their outputs.
module key_debounce_4
   import key_debounce_4_pkg::*;
#(
   parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_in,
   output logic       key_value0,
   output logic       key_flag0,
   output logic       key_value1,
   output logic       key_flag1,
   output logic       key_value2,
   output logic       key_flag2,
   output logic       key_value3,
   output logic       key_flag3
);

   logic [3:0] w_value;
   logic [3:0] w_flag;

   for (genvar g = 0; g < 4; g++) begin : g_ch
      key_filter_ch #(
         .DEB_CYCLES (DEB_CYCLES),
         .SYNC_STAGES(SYNC_STAGES)
      ) u_ch (
         .i_clk  (clk),
         .i_rst  (rst),
         .i_key  (key_in[g]),
         .o_value(w_value[g]),
         .o_flag (w_flag[g])
      );
   end

   assign key_value0 = w_value[0];
   assign key_value1 = w_value[1];
   assign key_value2 = w_value[2];
   assign key_value3 = w_value[3];
   assign key_flag0  = w_flag[0];
   assign key_flag1  = w_flag[1];
   assign key_flag2  = w_flag[2];
   assign key_flag3  = w_flag[3];

endmodule

// File: tb/tb_key_debounce_4.sv
// Directed bench for key_debounce_4 with DEB_CYCLES=16: checks flag timing
// (E0+18), bounce rejection, glitch rejection, release and reset abort.
module tb_key_debounce_4;

   logic       clk;
   logic       rst;
   logic [3:0] key_in;
   logic       kv0, kv1, kv2, kv3, kf0, kf1, kf2, kf3;
   logic [3:0] val, flg;

   int vecs = 0;
   int errs = 0;

   assign val = {kv3, kv2, kv1, kv0};
   assign flg = {kf3, kf2, kf1, kf0};

   key_debounce_4 #(.DEB_CYCLES(16), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in),
      .key_value0(kv0),
      .key_flag0 (kf0),
      .key_value1(kv1),
      .key_flag1 (kf1),
      .key_value2(kv2),
      .key_flag2 (kf2),
      .key_value3(kv3),
      .key_flag3 (kf3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // inputs change and outputs are sampled 1 ns after each rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] ef, ev;
      rst = 1'b1;
      key_in = 4'b0000;
      repeat (3) tick();
      vecs++; if (val !== 4'hF) begin errs++; $display("FAIL reset_value got=%b exp=%b", val, 4'hF); end
      vecs++; if (flg !== 4'h0) begin errs++; $display("FAIL reset_flag got=%b exp=%b", flg, 4'h0); end
      rst = 1'b0;
      for (int t = 0; t <= 22; t++) begin
         tick();
         ef = (t == 18) ? 4'hF : 4'h0;
         ev = (t >= 18) ? 4'h0 : 4'hF;
         vecs++; if (flg !== ef) begin errs++; $display("FAIL post_reset_flag t=%0d got=%b exp=%b", t, flg, ef); end
         vecs++; if (val !== ev) begin errs++; $display("FAIL post_reset_value t=%0d got=%b exp=%b", t, val, ev); end
      end
      key_in = 4'hF;
      for (int t = 0; t <= 22; t++) begin
         tick();
         ef = (t == 18) ? 4'hF : 4'h0;
         vecs++; if (flg !== ef) begin errs++; $display("FAIL release_all_flag t=%0d got=%b exp=%b", t, flg, ef); end
      end
      vecs++; if (val !== 4'hF) begin errs++; $display("FAIL release_all_value got=%b exp=%b", val, 4'hF); end
   endtask

   task automatic test_clean_press();
      logic [3:0] ef, ev;
      key_in = 4'b1110;
      for (int t = 0; t < 40; t++) begin
         tick();
         ef = (t == 18) ? 4'b0001 : 4'b0000;
         ev = (t >= 18) ? 4'b1110 : 4'b1111;
         vecs++; if (flg !== ef) begin errs++; $display("FAIL press_flag t=%0d got=%b exp=%b", t, flg, ef); end
         vecs++; if (val !== ev) begin errs++; $display("FAIL press_value t=%0d got=%b exp=%b", t, val, ev); end
      end
      key_in = 4'hF;
      repeat (25) tick();
      vecs++; if (val !== 4'hF) begin errs++; $display("FAIL press_restore got=%b exp=%b", val, 4'hF); end
   endtask

   task automatic test_bounce();
      logic [3:0] ef, ev;
      for (int t = 0; t < 56; t++) begin
         if (t < 30) key_in = {2'b11, ((t / 3) % 2 == 0) ? 1'b0 : 1'b1, 1'b1};
         else        key_in = 4'b1101;
         tick();
         ef = (t == 48) ? 4'b0010 : 4'b0000;
         ev = (t >= 48) ? 4'b1101 : 4'b1111;
         vecs++; if (flg !== ef) begin errs++; $display("FAIL bounce_flag t=%0d got=%b exp=%b", t, flg, ef); end
         vecs++; if (val !== ev) begin errs++; $display("FAIL bounce_value t=%0d got=%b exp=%b", t, val, ev); end
      end
      key_in = 4'hF;
      repeat (25) tick();
      vecs++; if (val !== 4'hF) begin errs++; $display("FAIL bounce_restore got=%b exp=%b", val, 4'hF); end
   endtask

   task automatic test_glitch();
      for (int t = 0; t < 45; t++) begin
         key_in = (t < 15) ? 4'b1011 : 4'b1111;
         tick();
         vecs++; if (flg !== 4'h0) begin errs++; $display("FAIL glitch_flag t=%0d got=%b exp=%b", t, flg, 4'h0); end
         vecs++; if (val !== 4'hF) begin errs++; $display("FAIL glitch_value t=%0d got=%b exp=%b", t, val, 4'hF); end
      end
   endtask

   task automatic test_release();
      logic [3:0] ef, ev;
      key_in = 4'b0111;
      repeat (25) tick();
      vecs++; if (val !== 4'b0111) begin errs++; $display("FAIL release_setup got=%b exp=%b", val, 4'b0111); end
      key_in = 4'hF;
      for (int t = 0; t <= 30; t++) begin
         tick();
         ef = (t == 18) ? 4'b1000 : 4'b0000;
         ev = (t >= 18) ? 4'b1111 : 4'b0111;
         vecs++; if (flg !== ef) begin errs++; $display("FAIL release_flag t=%0d got=%b exp=%b", t, flg, ef); end
         vecs++; if (val !== ev) begin errs++; $display("FAIL release_value t=%0d got=%b exp=%b", t, val, ev); end
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] ef, ev;
      key_in = 4'b0000;
      for (int t = 0; t <= 25; t++) begin
         tick();
         ef = (t == 18) ? 4'hF : 4'h0;
         ev = (t >= 18) ? 4'h0 : 4'hF;
         vecs++; if (flg !== ef) begin errs++; $display("FAIL simul_flag t=%0d got=%b exp=%b", t, flg, ef); end
         vecs++; if (val !== ev) begin errs++; $display("FAIL simul_value t=%0d got=%b exp=%b", t, val, ev); end
      end
      key_in = 4'hF;
      repeat (25) tick();
      vecs++; if (val !== 4'hF) begin errs++; $display("FAIL simul_restore got=%b exp=%b", val, 4'hF); end
   endtask

   task automatic test_reset_abort();
      logic [3:0] ef, ev;
      key_in = 4'b0000;
      for (int t = 0; t < 12; t++) begin
         tick();
         vecs++; if (flg !== 4'h0) begin errs++; $display("FAIL abort_pre_flag t=%0d got=%b exp=%b", t, flg, 4'h0); end
      end
      rst = 1'b1;
      repeat (2) tick();
      vecs++; if (flg !== 4'h0) begin errs++; $display("FAIL abort_rst_flag got=%b exp=%b", flg, 4'h0); end
      vecs++; if (val !== 4'hF) begin errs++; $display("FAIL abort_rst_value got=%b exp=%b", val, 4'hF); end
      rst = 1'b0;
      // filter must restart from scratch: flag lands exactly 18 edges later
      for (int t = 0; t <= 22; t++) begin
         tick();
         ef = (t == 18) ? 4'hF : 4'h0;
         ev = (t >= 18) ? 4'h0 : 4'hF;
         vecs++; if (flg !== ef) begin errs++; $display("FAIL abort_flag t=%0d got=%b exp=%b", t, flg, ef); end
         vecs++; if (val !== ev) begin errs++; $display("FAIL abort_value t=%0d got=%b exp=%b", t, val, ev); end
      end
      key_in = 4'hF;
      repeat (25) tick();
   endtask

   initial begin
      rst = 1'b1;
      key_in = 4'hF;
      test_reset();
      test_clean_press();
      test_bounce();
      test_glitch();
      test_release();
      test_simultaneous();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
